// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI responder that oversamples sclk/cs_n/mosi on clk and supports all four SPI modes.
// Define SPI_SLAVE_LSB_FIRST_EN for LSB-first framing on both mosi and miso (default MSB first).
module spi_slave_if #(
  parameter int BIT_WIDTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 sclk,
  input  logic                 cs_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  input  logic [BIT_WIDTH-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [BIT_WIDTH-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 tx_underrun,
  output logic                 busy
);

  localparam int               CNT_W    = $clog2(BIT_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIT_WIDTH - 1);

  typedef enum logic [1:0] {MISO_IDLE, START_RX, RECIEVE, END_RX} miso_states;

  miso_states state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_s, sclk_d, cs_s, cs_d, mosi_s;
  logic [1:0]             mode_q;
  logic [CNT_W-1:0]       bit_cnt;
  logic [BIT_WIDTH-1:0]   rx_shift, rx_next;
  logic [BIT_WIDTH-1:0]   tx_shift, tx_rest, load_word, load_rest;
  logic                   tx_first, load_first, miso_bit;
  logic [BIT_WIDTH-1:0]   hold_q;
  logic                   hold_full;
  logic                   cpol, cpha, sclk_edge, lead_edge, trail_edge;
  logic                   sample_en, shift_en, last_sample, load_en;
  logic                   bypass, underrun_now, cs_fall;

  // Synchronisers are left unreset so a cs_n still held low across rst cannot fake a fresh select.
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
    cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    sclk_d    <= sclk_s;
    cs_d      <= cs_s;
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign cpol         = mode_q[1];
  assign cpha         = mode_q[0];
  assign sclk_edge    = sclk_s ^ sclk_d;
  assign lead_edge    = sclk_edge & (sclk_s ^ cpol);
  assign trail_edge   = sclk_edge & ~(sclk_s ^ cpol);
  assign sample_en    = (state == RECIEVE) & (cpha ? trail_edge : lead_edge);
  assign shift_en     = (state == RECIEVE) & (cpha ? lead_edge : trail_edge);
  assign last_sample  = sample_en & (bit_cnt == LAST_BIT);
  assign load_en      = (state == START_RX) | last_sample;
  assign bypass       = load_en & ~hold_full & tx_valid;
  assign underrun_now = load_en & ~hold_full & ~tx_valid;
  assign load_word    = hold_full ? hold_q : (tx_valid ? tx_data : '0);
  assign cs_fall      = cs_d & ~cs_s;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_next    = {mosi_s, rx_shift[BIT_WIDTH-1:1]};
  assign tx_first   = tx_shift[0];
  assign tx_rest    = tx_shift >> 1;
  assign load_first = load_word[0];
  assign load_rest  = load_word >> 1;
`else
  assign rx_next    = {rx_shift[BIT_WIDTH-2:0], mosi_s};
  assign tx_first   = tx_shift[BIT_WIDTH-1];
  assign tx_rest    = tx_shift << 1;
  assign load_first = load_word[BIT_WIDTH-1];
  assign load_rest  = load_word << 1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= MISO_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    miso_oe   = 1'b0;
    busy      = 1'b1;
    case (state)
      MISO_IDLE: begin
        busy = 1'b0;
        if (cs_fall) state_nxt = START_RX;
      end
      START_RX: begin
        miso_oe   = 1'b1;
        state_nxt = RECIEVE;
      end
      RECIEVE: begin
        miso_oe = 1'b1;
        if (cs_s) state_nxt = END_RX;
      end
      END_RX:  state_nxt = MISO_IDLE;
      default: state_nxt = MISO_IDLE;
    endcase
    miso     = miso_oe & miso_bit;
    tx_ready = ~hold_full;
  end

  // A word reload at the final sample keeps back-to-back words seamless under one cs_n.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= 2'b00;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      miso_bit    <= 1'b0;
      hold_q      <= '0;
      hold_full   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= underrun_now;

      if (load_en && hold_full) begin
        hold_full <= 1'b0;
      end else if (tx_valid && !hold_full && !bypass) begin
        hold_q    <= tx_data;
        hold_full <= 1'b1;
      end

      if (state == START_RX) begin
        mode_q  <= mode;
        bit_cnt <= '0;
        if (!mode[0]) begin
          miso_bit <= load_first;
          tx_shift <= load_rest;
        end else begin
          miso_bit <= 1'b0;
          tx_shift <= load_word;
        end
      end else if (state == RECIEVE) begin
        if (sample_en) begin
          rx_shift <= rx_next;
          if (last_sample) begin
            bit_cnt  <= '0;
            rx_data  <= rx_next;
            rx_valid <= 1'b1;
            tx_shift <= load_word;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        if (shift_en) begin
          miso_bit <= tx_first;
          tx_shift <= tx_rest;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: scoreboard bench for spi_slave_if acting as the SPI master on the pins.
// Expected rx words and miso words are queued at stimulus time and popped by a monitor.
module tb_spi_slave_if;

  localparam int BW   = 32;
  localparam int SYNC = 2;
  localparam int HP   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic          sclk = 1'b0;
  logic          cs_n = 1'b1;
  logic          mosi = 1'b0;
  logic          miso, miso_oe;
  logic [BW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [BW-1:0] rx_data;
  logic          rx_valid, tx_underrun, busy;

  int            total = 0;
  int            bad = 0;
  int            underrun_cnt = 0;
  logic [BW-1:0] exp_rx[$];
  logic [BW-1:0] exp_miso[$];
  logic [BW-1:0] miso_got[$];

  spi_slave_if #(.BIT_WIDTH(BW), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_hp();
    repeat (HP) @(posedge clk);
    #2;
  endtask

  task automatic tx_write(input logic [BW-1:0] w);
    int n = 0;
    @(posedge clk); #1;
    while (!tx_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!tx_ready) begin
      checkOutput("tx_ready_timeout", {31'd0, tx_ready}, 32'd1);
    end else begin
      tx_data  = w;
      tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b0;
    end
  endtask

  task automatic cs_select(input logic [1:0] m);
    mode = m;
    sclk = m[1];
    wait_hp();
    cs_n = 1'b0;
    wait_hp();
    wait_hp();
  endtask

  task automatic cs_release();
    logic dropped = 1'b0;
    wait_hp();
    cs_n = 1'b1;
    for (int k = 0; k < SYNC + 2; k++) begin
      @(posedge clk); #1;
      if (!miso_oe) begin
        dropped = 1'b1;
        break;
      end
    end
    checkOutput("miso_oe_release", {31'd0, dropped}, 32'd1);
    wait_hp();
    wait_hp();
  endtask

  // Master side of one word: sends the top nbits of word MSB first, captures miso.
  task automatic spi_word(input logic [BW-1:0] word, input int nbits, output logic [BW-1:0] got);
    logic cpol, cpha;
    int   oe_low = 0;
    cpol = mode[1];
    cpha = mode[0];
    got  = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = word[5'(31 - i)];
        wait_hp();
        got  = {got[BW-2:0], miso};
        sclk = ~cpol;
        wait_hp();
        sclk = cpol;
      end else begin
        wait_hp();
        sclk = ~cpol;
        mosi = word[5'(31 - i)];
        wait_hp();
        got  = {got[BW-2:0], miso};
        sclk = cpol;
      end
      if (!miso_oe) oe_low++;
    end
    checkOutput("miso_oe_active", 32'(oe_low), 32'd0);
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [BW-1:0] tx_w, input logic [BW-1:0] rx_w);
    logic [BW-1:0] got;
    tx_write(tx_w);
    exp_rx.push_back(rx_w);
    exp_miso.push_back(tx_w);
    cs_select(m);
    spi_word(rx_w, BW, got);
    miso_got.push_back(got);
    cs_release();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_miso"},        {31'd0, miso},        32'd0);
    checkOutput({tag, "_miso_oe"},     {31'd0, miso_oe},     32'd0);
    checkOutput({tag, "_rx_data"},     rx_data,              32'd0);
    checkOutput({tag, "_rx_valid"},    {31'd0, rx_valid},    32'd0);
    checkOutput({tag, "_tx_underrun"}, {31'd0, tx_underrun}, 32'd0);
    checkOutput({tag, "_busy"},        {31'd0, busy},        32'd0);
    checkOutput({tag, "_tx_ready"},    {31'd0, tx_ready},    32'd1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (tx_underrun) underrun_cnt++;
      if (!rst && rx_valid) begin
        if (exp_rx.size() == 0) checkOutput("rx_valid_unexpected", {31'd0, rx_valid}, 32'd0);
        else checkOutput("rx_data", rx_data, exp_rx.pop_front());
      end
      if (miso_got.size() > 0 && exp_miso.size() > 0)
        checkOutput("miso_word", miso_got.pop_front(), exp_miso.pop_front());
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [BW-1:0] got;
    int            ur_before;
    int            busy_seen;

    repeat (5) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b0;
    repeat (4) @(posedge clk);

    $display("[TB] mode0 single word");
    applyStimulus(2'd0, 32'hA5A5_0F0F, 32'h1234_5678);
    checkOutput("rx_data_held", rx_data, 32'h1234_5678);

    for (int m = 1; m < 4; m++) begin
      $display("[TB] mode%0d exchange", m);
      applyStimulus(2'(m), 32'hDEAD_BEEF, 32'hCAFE_F00D);
    end

    $display("[TB] two words under one select");
    tx_write(32'h8000_0001);
    exp_rx.push_back(32'h0000_0001);
    exp_rx.push_back(32'h0000_0002);
    cs_select(2'd0);
    tx_write(32'h4000_0002);
    exp_miso.push_back(32'h8000_0001);
    spi_word(32'h0000_0001, BW, got);
    miso_got.push_back(got);
    exp_miso.push_back(32'h4000_0002);
    spi_word(32'h0000_0002, BW, got);
    miso_got.push_back(got);
    cs_release();

    // Late word lands after the first load, so only the select-time load underruns.
    $display("[TB] underrun");
    ur_before = underrun_cnt;
    exp_rx.push_back(32'h0F0F_F0F0);
    exp_miso.push_back(32'h0000_0000);
    cs_select(2'd0);
    fork
      spi_word(32'h0F0F_F0F0, BW, got);
      begin
        repeat (10 * HP) @(posedge clk);
        tx_write(32'hFFFF_FFFF);
      end
    join
    miso_got.push_back(got);
    cs_release();
    checkOutput("underrun_pulses", 32'(underrun_cnt - ur_before), 32'd1);
    checkOutput("tx_ready_after_underrun", {31'd0, tx_ready}, 32'd1);

    $display("[TB] partial word");
    cs_select(2'd0);
    spi_word(32'hFFFF_0000, 13, got);
    cs_release();
    checkOutput("rx_data_after_partial", rx_data, 32'h0F0F_F0F0);

    $display("[TB] reset mid-transfer");
    tx_write(32'h0BAD_CAFE);
    cs_select(2'd0);
    tx_write(32'h7777_7777);
    checkOutput("tx_ready_full", {31'd0, tx_ready}, 32'd0);
    spi_word(32'hFFFF_FFFF, 20, got);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkResetValues("mid_rst");
    rst = 1'b0;
    busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (busy) busy_seen++;
    end
    checkOutput("no_restart_without_select", 32'(busy_seen), 32'd0);
    cs_n = 1'b1;
    wait_hp();
    wait_hp();
    applyStimulus(2'd0, 32'h1357_9BDF, 32'h2468_ACE0);

    repeat (5) @(posedge clk);
    checkOutput("rx_expect_drained",   32'(exp_rx.size()),   32'd0);
    checkOutput("miso_expect_drained", 32'(exp_miso.size()), 32'd0);
    checkOutput("miso_got_drained",    32'(miso_got.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
